// File: rtl/wb_host_bridge_pkg.sv
// wb_host_bridge_pkg: shared definitions for the host byte-stream to Wishbone bridge.
//  - command header bit positions
//  - response status codes and FSM state encodings
//  - helper that packs the response status byte
package wb_host_bridge_pkg;

  // Header byte layout: {WE, rsvd, ADR[13:8]}
  localparam int unsigned HdrWeBit   = 7;
  localparam int unsigned HdrRsvdBit = 6;
  localparam int unsigned HdrAdrHiW  = 6;

  // Full address width carried by a frame (header high bits + adrlo byte)
  localparam int unsigned FrameAdrW  = 14;

  typedef enum logic [1:0] {
    StOk      = 2'd0,
    StTimeout = 2'd1,
    StBadCmd  = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    StHdr     = 3'd0,
    StAdrLo   = 3'd1,
    StWdata   = 3'd2,
    StBus     = 3'd3,
    StRspStat = 3'd4,
    StRspData = 3'd5
  } state_e;

  // Status byte returned to the host: WE in bit 7, status code in bits 1:0.
  function automatic logic [7:0] status_byte(input logic we, input status_e st);
    return {we, 5'b00000, st};
  endfunction

endpackage

// File: rtl/wb_host_shift32.sv
// wb_host_shift32: 4-byte register addressed by a 2-bit byte index.
//  Assembles write data one byte at a time (LSB first) and serialises captured
//  read data one byte at a time (LSB first).
// Ports:
//  clk, rst_n  clock, async active-low reset
//  clr         return byte index to 0
//  wr          store byte_in at current index, advance index
//  load        load load_data in parallel, index to 0 (wins over other ops)
//  adv         advance index without writing
//  byte_in     byte to store
//  load_data   parallel load value
//  data        full 32-bit contents
//  byte_out    byte at current index
//  last        current index is 3
module wb_host_shift32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr,
  input  logic        load,
  input  logic        adv,
  input  logic [7:0]  byte_in,
  input  logic [31:0] load_data,
  output logic [31:0] data,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [31:0] data_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      data_q <= load_data;
      idx_q  <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (wr) begin
      data_q[{idx_q, 3'b000} +: 8] <= byte_in;
      idx_q                        <= idx_q + 2'd1;
    end else if (adv) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  assign data     = data_q;
  assign byte_out = data_q[{idx_q, 3'b000} +: 8];
  assign last     = (idx_q == 2'd3);

endmodule

// File: rtl/wb_host_bridge.sv
// wb_host_bridge: byte-stream command interpreter acting as a Wishbone classic
// initiator. Each frame {hdr, adrlo, [4 data bytes if WE]} runs one single-beat
// 32-bit cycle; the host gets a status byte, plus 4 data bytes for a good read.
// Ports:
//  clk, rst_n                  ctrl clock, async active-low reset
//  cmd_valid/cmd_data/cmd_ready   command byte stream in
//  rsp_valid/rsp_data/rsp_ready   response byte stream out
//  wb_CYC/STB/WE/SEL/ADR/DAT_MOSI Wishbone initiator outputs (SEL fixed 4'hF)
//  wb_DAT_MISO/wb_ACK             Wishbone slave returns
//  busy                        high whenever a frame is in progress
module wb_host_bridge
  import wb_host_bridge_pkg::*;
#(
  parameter int unsigned ADR_W   = 14,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_data,
  output logic             cmd_ready,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  input  logic             rsp_ready,
  output logic             wb_CYC,
  output logic             wb_STB,
  output logic             wb_WE,
  output logic [3:0]       wb_SEL,
  output logic [ADR_W-1:0] wb_ADR,
  output logic [31:0]      wb_DAT_MOSI,
  input  logic [31:0]      wb_DAT_MISO,
  input  logic             wb_ACK,
  output logic             busy
);

  localparam logic [TO_W-1:0] ToLimit = TO_W'(TIMEOUT);
  localparam bit              ToEn    = (TIMEOUT != 0);

  state_e                 state_q;
  logic                   we_q;
  logic                   bad_q;
  logic [FrameAdrW-1:0]   adr_q;
  status_e                status_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic                   cyc_q;
  logic                   cmd_ready_q;
  logic                   rsp_valid_q;
  logic                   busy_q;

  logic                   cmd_fire;
  logic                   rsp_fire;
  logic                   bus_ack;
  logic                   bus_to;
  logic                   frame_done;

  logic                   sh_clr;
  logic                   sh_wr;
  logic                   sh_load;
  logic                   sh_adv;
  logic [31:0]            sh_data;
  logic [7:0]             sh_byte;
  logic                   sh_last;

  assign cmd_fire = cmd_valid & cmd_ready_q;
  assign rsp_fire = rsp_valid_q & rsp_ready;

  // ACK outside BUS is ignored; ACK beats timeout when both land on one cycle.
  assign bus_ack = (state_q == StBus) & wb_ACK;
  assign bus_to  = (state_q == StBus) & ~wb_ACK & ToEn & (to_cnt_q == ToLimit);

  // Last byte of the frame accepted (reads end at adrlo, writes at 4th data byte)
  assign frame_done = cmd_fire & (((state_q == StAdrLo) & ~we_q) |
                                  ((state_q == StWdata) & sh_last));

  // Shift register is shared: write assembly, then read-data serialisation.
  assign sh_clr  = (state_q == StHdr) & cmd_fire;
  assign sh_wr   = (state_q == StWdata) & cmd_fire;
  assign sh_load = (bus_ack | bus_to) & ~we_q;
  assign sh_adv  = (state_q == StRspData) & rsp_fire;

  wb_host_shift32 u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (sh_clr),
    .wr        (sh_wr),
    .load      (sh_load),
    .adv       (sh_adv),
    .byte_in   (cmd_data),
    .load_data (bus_ack ? wb_DAT_MISO : 32'h0),
    .data      (sh_data),
    .byte_out  (sh_byte),
    .last      (sh_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHdr;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      adr_q       <= '0;
      status_q    <= StOk;
      to_cnt_q    <= '0;
      cyc_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StHdr: begin
          if (cmd_fire) begin
            we_q                   <= cmd_data[HdrWeBit];
            bad_q                  <= cmd_data[HdrRsvdBit];
            adr_q[FrameAdrW-1:8]   <= cmd_data[HdrAdrHiW-1:0];
            busy_q                 <= 1'b1;
            state_q                <= StAdrLo;
          end
        end

        StAdrLo, StWdata: begin
          if ((state_q == StAdrLo) && cmd_fire) begin
            adr_q[7:0] <= cmd_data;
            if (we_q) begin
              state_q <= StWdata;
            end
          end
          if (frame_done) begin
            cmd_ready_q <= 1'b0;
            if (bad_q) begin
              // Malformed header: frame is swallowed, no bus cycle.
              status_q    <= StBadCmd;
              rsp_valid_q <= 1'b1;
              state_q     <= StRspStat;
            end else begin
              cyc_q    <= 1'b1;
              to_cnt_q <= '0;
              state_q  <= StBus;
            end
          end
        end

        StBus: begin
          if (bus_ack) begin
            cyc_q       <= 1'b0;
            status_q    <= StOk;
            rsp_valid_q <= 1'b1;
            state_q     <= StRspStat;
          end else if (bus_to) begin
            cyc_q       <= 1'b0;
            status_q    <= StTimeout;
            rsp_valid_q <= 1'b1;
            state_q     <= StRspStat;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        StRspStat: begin
          if (rsp_fire) begin
            if (!we_q && (status_q == StOk)) begin
              state_q <= StRspData;
            end else begin
              rsp_valid_q <= 1'b0;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= StHdr;
            end
          end
        end

        StRspData: begin
          if (rsp_fire && sh_last) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StHdr;
          end
        end

        default: begin
          cyc_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StHdr;
        end
      endcase
    end
  end

  always_comb begin
    rsp_data = 8'h00;
    if (state_q == StRspStat) begin
      rsp_data = status_byte(we_q, status_q);
    end else if (state_q == StRspData) begin
      rsp_data = sh_byte;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign busy        = busy_q;
  assign wb_CYC      = cyc_q;
  assign wb_STB      = cyc_q;
  assign wb_WE       = cyc_q & we_q;
  assign wb_SEL      = 4'hF;
  assign wb_ADR      = adr_q[ADR_W-1:0];
  assign wb_DAT_MOSI = sh_data;

endmodule

// File: tb/tb_wb_host_bridge.sv
module tb_wb_host_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ready;
  logic        wb_CYC;
  logic        wb_STB;
  logic        wb_WE;
  logic [3:0]  wb_SEL;
  logic [13:0] wb_ADR;
  logic [31:0] wb_DAT_MOSI;
  logic [31:0] wb_DAT_MISO;
  logic        wb_ACK;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_rsp[$];

  // Slave model controls and observations
  logic        ack_en    = 1'b1;
  int          ack_delay = 1;
  logic [31:0] miso_val  = 32'h0;
  logic        stray_ack = 1'b0;
  int          n_bus     = 0;
  int          cur_len   = 0;
  int          last_len  = 0;
  logic        in_cyc    = 1'b0;
  logic [13:0] cap_adr;
  logic [31:0] cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  // Response-side controls
  logic hold_rsp   = 1'b0;
  logic rand_ready = 1'b0;

  wb_host_bridge #(
    .ADR_W   (14),
    .TIMEOUT (4),
    .TO_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready),
    .wb_CYC      (wb_CYC),
    .wb_STB      (wb_STB),
    .wb_WE       (wb_WE),
    .wb_SEL      (wb_SEL),
    .wb_ADR      (wb_ADR),
    .wb_DAT_MOSI (wb_DAT_MOSI),
    .wb_DAT_MISO (wb_DAT_MISO),
    .wb_ACK      (wb_ACK),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wishbone slave: ACK after ack_delay cycles of CYC, records each bus cycle.
  initial begin
    wb_ACK      = 1'b0;
    wb_DAT_MISO = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_CYC) begin
        if (!in_cyc) begin
          in_cyc  = 1'b1;
          n_bus++;
          cur_len = 0;
          cap_adr = wb_ADR;
          cap_dat = wb_DAT_MOSI;
          cap_we  = wb_WE;
          cap_sel = wb_SEL;
        end else begin
          check_eq("bus_adr_stable", 32'(wb_ADR), 32'(cap_adr));
          check_eq("bus_we_stable", 32'(wb_WE), 32'(cap_we));
        end
        check_eq("bus_stb_eq_cyc", 32'(wb_STB), 32'd1);
        cur_len++;
        wb_ACK      = ack_en && (cur_len == ack_delay);
        wb_DAT_MISO = wb_ACK ? miso_val : 32'hA5A5_A5A5;
      end else begin
        if (in_cyc) begin
          in_cyc   = 1'b0;
          last_len = cur_len;
        end
        wb_ACK      = stray_ack;
        wb_DAT_MISO = 32'hFFFF_FFFF;
      end
    end
  end

  // Response ready driver
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_rsp)        rsp_ready = 1'b0;
      else if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
      else                 rsp_ready = 1'b1;
    end
  end

  // Response monitor: a byte transfers on the edge after valid&ready is seen here.
  initial forever begin
    @(negedge clk);
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) check_eq("rsp_unexpected", 32'(exp_rsp.size()), 32'd1);
      else                     check_eq("rsp_byte", 32'(rsp_data), 32'(exp_rsp.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  task automatic push_read(input logic [31:0] d);
    exp_rsp.push_back(8'h00);
    for (int i = 0; i < 4; i++) exp_rsp.push_back(d[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_rsp.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_queue", 32'(exp_rsp.size()), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input string tag, input bit want_cyc);
    int n = 0;
    while (!(want_cyc ? wb_CYC : rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, want_cyc ? 32'(wb_CYC) : 32'(rsp_valid), 32'd1);
  endtask

  int nb;

  initial begin
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_cyc", 32'(wb_CYC), 32'd0);
    check_eq("rst_stb", 32'(wb_STB), 32'd0);
    check_eq("rst_we", 32'(wb_WE), 32'd0);
    check_eq("rst_sel", 32'(wb_SEL), 32'hF);
    check_eq("rst_adr", 32'(wb_ADR), 32'd0);
    check_eq("rst_mosi", wb_DAT_MOSI, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stray ACK while idle is ignored
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("stray_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("stray_busy", 32'(busy), 32'd0);
    end
    stray_ack = 1'b0;
    @(posedge clk);
    #1;
    check_eq("stray_no_bus", 32'(n_bus), 32'd0);

    // Write 0xDEADBEEF to 0x0234, ACK after 3 cycles
    ack_en = 1'b1; ack_delay = 3; nb = n_bus;
    exp_rsp.push_back(8'h80);
    send_byte(8'h82); send_byte(8'h34);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_idle();
    check_eq("wr_nbus", 32'(n_bus - nb), 32'd1);
    check_eq("wr_len", 32'(last_len), 32'd3);
    check_eq("wr_adr", 32'(cap_adr), 32'h0234);
    check_eq("wr_mosi", cap_dat, 32'hDEAD_BEEF);
    check_eq("wr_we", 32'(cap_we), 32'd1);
    check_eq("wr_sel", 32'(cap_sel), 32'hF);

    // Read 0x0110, ACK on first cycle
    ack_delay = 1; miso_val = 32'h1234_5678; nb = n_bus;
    push_read(32'h1234_5678);
    send_byte(8'h01); send_byte(8'h10);
    wait_idle();
    check_eq("rd_nbus", 32'(n_bus - nb), 32'd1);
    check_eq("rd_len", 32'(last_len), 32'd1);
    check_eq("rd_adr", 32'(cap_adr), 32'h0110);
    check_eq("rd_we", 32'(cap_we), 32'd0);

    // Timeout: no ACK, TIMEOUT=4 -> 5 cycles, status only
    ack_en = 1'b0; nb = n_bus;
    exp_rsp.push_back(8'h01);
    send_byte(8'h00); send_byte(8'h00);
    wait_sig("to_rsp_valid", 1'b0);
    check_eq("to_busy_during_rsp", 32'(busy), 32'd1);
    wait_idle();
    check_eq("to_nbus", 32'(n_bus - nb), 32'd1);
    check_eq("to_len", 32'(last_len), 32'd5);

    // ACK on the cycle the timeout is reached: ACK wins
    ack_en = 1'b1; ack_delay = 5; miso_val = 32'hCAFE_F00D;
    push_read(32'hCAFE_F00D);
    send_byte(8'h00); send_byte(8'h05);
    wait_idle();
    check_eq("edge_len", 32'(last_len), 32'd5);

    // Backpressure on the status byte of a read
    ack_delay = 2; miso_val = 32'h89AB_CDEF; nb = n_bus;
    hold_rsp = 1'b1;
    push_read(32'h89AB_CDEF);
    send_byte(8'h01); send_byte(8'h22);
    wait_sig("bp_rsp_valid", 1'b0);
    repeat (10) begin
      @(negedge clk);
      check_eq("bp_rsp_data", 32'(rsp_data), 32'h00);
      check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    check_eq("bp_nbus", 32'(n_bus - nb), 32'd1);
    hold_rsp = 1'b0;
    wait_idle();
    check_eq("bp_nbus_after", 32'(n_bus - nb), 32'd1);

    // Reserved header bit: frame swallowed, no bus cycle
    nb = n_bus;
    exp_rsp.push_back(8'h02);
    send_byte(8'h40); send_byte(8'h00);
    wait_idle();
    exp_rsp.push_back(8'h82);
    send_byte(8'hC0); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_idle();
    check_eq("bad_nbus", 32'(n_bus - nb), 32'd0);

    // Following good read with random response backpressure
    ack_delay = 1; miso_val = 32'h0BAD_CAFE; rand_ready = 1'b1;
    push_read(32'h0BAD_CAFE);
    send_byte(8'h01); send_byte(8'h00);
    wait_idle();
    rand_ready = 1'b0;
    check_eq("after_bad_nbus", 32'(n_bus - nb), 32'd1);
    check_eq("after_bad_adr", 32'(cap_adr), 32'h0100);

    // Reset in the middle of a bus cycle
    ack_en = 1'b0;
    send_byte(8'h00); send_byte(8'h33);
    wait_sig("mid_cyc", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cyc", 32'(wb_CYC), 32'd0);
    check_eq("mid_rst_stb", 32'(wb_STB), 32'd0);
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    ack_en = 1'b1; ack_delay = 1; miso_val = 32'h55AA_33CC; nb = n_bus;
    push_read(32'h55AA_33CC);
    send_byte(8'h01); send_byte(8'h3F);
    wait_idle();
    check_eq("post_rst_nbus", 32'(n_bus - nb), 32'd1);
    check_eq("post_rst_adr", 32'(cap_adr), 32'h013F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

endmodule
